ifu_fetch: RTL and testbench

- Instruction fetch unit: the producer end of the decode stage's pc/inst interface and the consumer of its branch redirect.
- Owns the fetch PC and drives a request/grant/response instruction-memory port.
- Buffers returned words in a small prefetch FIFO and presents {pc, inst, valid} to decode.
- On a redirect it flushes the buffer, discards in-flight responses and restarts fetch at the target.

---
 rtl/ifu_fetch_pkg.sv | 25 ++
 rtl/ifu_fifo.sv | 52 +++++
 rtl/ifu_fetch.sv | 108 ++++++++++
 tb/tb_ifu_fetch.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam inst_t      INST_NOP         = 32'h0000_0013;
    localparam inst_addr_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    function automatic inst_addr_t align_word(input inst_addr_t addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer holding {pc, inst} pairs; clear wins over push and pop.
module ifu_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rdata  = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited memory
// requests, buffers responses and presents {pc, inst, valid} to decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter inst_addr_t RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e  state;
    inst_addr_t    fetch_pc;
    inst_addr_t    resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_on_branch;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          granted;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  resp_entry;

    // Handshakes: a request transfers when imem_req_o & imem_gnt_i, and req/addr
    // hold until then; an instruction transfers to decode when inst_valid_o & ~stall_i.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_o  = (state == ST_RUN) && (credit_used < CREDIT_MAX);
    assign imem_addr_o = fetch_pc;
    assign granted     = imem_req_o && imem_gnt_i;

    // Responses still owed after a redirect are exactly the stale ones.
    assign discard_on_branch = outstanding + CW'(granted) - CW'(imem_rvalid_i);

    assign fifo_push  = imem_rvalid_i && !branch_i && (discard == '0) && (!fifo_full || fifo_pop);
    assign fifo_pop   = inst_valid_o && !stall_i && !branch_i;
    assign resp_entry = '{pc: resp_pc, inst: imem_rdata_i};

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (branch_i),
        .wdata (resp_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign inst_valid_o = !fifo_empty;
    assign pc_o         = inst_valid_o ? head.pc : resp_pc;
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;

    // IDLE only lasts one cycle so the first request rises after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(granted) - CW'(imem_rvalid_i);
            if (branch_i) begin
                fetch_pc <= align_word(branch_pc_i);
                resp_pc  <= align_word(branch_pc_i);
                discard  <= discard_on_branch;
                state    <= (discard_on_branch != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                if (granted) fetch_pc <= fetch_pc + 32'd4;
                if (fifo_push) resp_pc <= resp_pc + 32'd4;
                case (state)
                    ST_IDLE: state <= ST_RUN;
                    ST_FLUSH: begin
                        if (imem_rvalid_i) begin
                            discard <= discard - 1'b1;
                            if (discard == CW'(1)) state <= ST_RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: memory model with epoch-tagged responses
// feeding an expected {pc, inst} queue that decode-side outputs are checked against.
`timescale 1ns/1ps
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } mem_ent_t;

    logic        clk;
    logic        rst_n;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    ifu_fetch #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_i      (branch_i),
        .branch_pc_i   (branch_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          cyc;
    int          epoch;
    int          lat;
    bit          started;
    logic        gnt_v;
    logic        stall_v;
    logic        rvalid_v;
    logic        branch_v;
    logic [31:0] branch_tgt;
    logic [31:0] exp_fetch_pc;
    bit          acc_flag;
    logic [31:0] acc_pc;

    mem_ent_t    mem_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit has_stale();
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_assert();
        #2;
        rst_n         = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        branch_i      = 1'b0;
        stall_i       = 1'b0;
        branch_v      = 1'b0;
        stall_v       = 1'b0;
        mem_q.delete();
        exp_q.delete();
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n        = 1'b1;
        epoch        = 0;
        cyc          = 0;
        started      = 1'b0;
        exp_fetch_pc = RST_PC;
        mem_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver / memory model / scoreboard ----------------
    // Called at a negedge: checks settled outputs, drives this cycle's inputs,
    // updates the model for the coming posedge, then advances to the next negedge.
    task automatic step();
        logic     exp_req;
        logic     rsp;
        logic     stale;
        logic     acc;
        mem_ent_t e;
        e       = '0;
        stale   = 1'b0;
        exp_req = started && !has_stale() && ((mem_q.size() + exp_q.size()) < DEPTH);
        checks++;
        if (imem_req_o !== exp_req) begin
            failures++;
            $display("FAIL req cyc%0d: got %0b exp %0b", cyc, imem_req_o, exp_req);
        end
        if (imem_req_o === 1'b1) begin
            checks++;
            if (imem_addr_o !== exp_fetch_pc) begin
                failures++;
                $display("FAIL addr cyc%0d: got %h exp %h", cyc, imem_addr_o, exp_fetch_pc);
            end
        end
        checks++;
        if (inst_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_valid cyc%0d: got pc %h exp no instruction", cyc, pc_o);
            end else if ({pc_o, inst_o} !== exp_q[0]) begin
                failures++;
                $display("FAIL present cyc%0d: got %h/%h exp %h/%h", cyc, pc_o, inst_o,
                         exp_q[0][63:32], exp_q[0][31:0]);
            end
        end else if (inst_o !== NOP) begin
            failures++;
            $display("FAIL nop cyc%0d: got %h exp %h", cyc, inst_o, NOP);
        end
        acc      = (inst_valid_o === 1'b1) && !stall_v && !branch_v;
        acc_flag = acc;
        acc_pc   = pc_o;
        if (acc && exp_q.size() > 0) void'(exp_q.pop_front());

        imem_gnt_i    = gnt_v;
        stall_i       = stall_v;
        branch_i      = branch_v;
        branch_pc_i   = branch_tgt;
        rsp           = rvalid_v && (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? inst_of(mem_q[0].addr) : 32'h0;
        if (rsp) begin
            e     = mem_q.pop_front();
            stale = (e.epoch != epoch);
        end
        if (imem_req_o && gnt_v) begin
            mem_q.push_back('{addr: imem_addr_o, epoch: epoch, ready: cyc + lat});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (branch_v) begin
            exp_q.delete();
            epoch++;
            exp_fetch_pc = {branch_tgt[31:2], 2'b00};
        end else if (rsp && !stale) begin
            checks++;
            if (exp_q.size() >= DEPTH) begin
                failures++;
                $display("FAIL push_at_full cyc%0d: got %0d entries exp below %0d", cyc, exp_q.size(), DEPTH);
            end
            exp_q.push_back({e.addr, inst_of(e.addr)});
        end
        @(posedge clk);
        started = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks += 5;
        if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b exp 0", imem_req_o); end
        if (imem_addr_o !== RST_PC) begin failures++; $display("FAIL rst_addr: got %h exp %h", imem_addr_o, RST_PC); end
        if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", inst_valid_o); end
        if (pc_o !== RST_PC) begin failures++; $display("FAIL rst_pc: got %h exp %h", pc_o, RST_PC); end
        if (inst_o !== NOP) begin failures++; $display("FAIL rst_inst: got %h exp %h", inst_o, NOP); end
        reset_release();
    endtask

    task automatic test_stream();
        int          first;
        logic [31:0] first_pc;
        first    = -1;
        first_pc = 32'hx;
        gnt_v    = 1'b1;
        rvalid_v = 1'b1;
        stall_v  = 1'b0;
        lat      = 1;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid_o === 1'b1 && first < 0) begin
                first    = cyc;
                first_pc = pc_o;
            end
            step();
        end
        checks += 2;
        if (first != 3) begin failures++; $display("FAIL first_valid_cycle: got %0d exp 3", first); end
        if (first_pc !== RST_PC) begin failures++; $display("FAIL first_pc: got %h exp %h", first_pc, RST_PC); end
    endtask

    task automatic test_stall();
        bit          held;
        logic [31:0] hold_pc;
        logic [31:0] hold_inst;
        held      = 1'b0;
        hold_pc   = 32'h0;
        hold_inst = 32'h0;
        stall_v   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (inst_valid_o === 1'b1) begin
                if (held) begin
                    checks++;
                    if (pc_o !== hold_pc || inst_o !== hold_inst) begin
                        failures++;
                        $display("FAIL stall_frozen: got %h/%h exp %h/%h", pc_o, inst_o, hold_pc, hold_inst);
                    end
                end else begin
                    held      = 1'b1;
                    hold_pc   = pc_o;
                    hold_inst = inst_o;
                end
            end
            if (i == 5) begin
                checks++;
                if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stall_req_drop: got %b exp 0", imem_req_o); end
            end
            step();
        end
        stall_v = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_gnt_hold();
        reset_assert();
        reset_release();
        gnt_v = 1'b1;
        lat   = 1;
        for (int i = 0; i < 20 && exp_fetch_pc != 32'h8; i++) step();
        gnt_v = 1'b0;
        for (int i = 0; i < 10 && imem_req_o !== 1'b1; i++) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
                failures++;
                $display("FAIL gnt_hold: got req %b addr %h exp req 1 addr 00000008", imem_req_o, imem_addr_o);
            end
            step();
        end
        gnt_v = 1'b1;
        step();
        checks++;
        if (mem_q.size() == 0 || mem_q[mem_q.size() - 1].addr !== 32'h8) begin
            failures++;
            $display("FAIL gnt_hold_grant: granted address not 00000008 (%0d pending)", mem_q.size());
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_branch();
        bit          seen_req;
        bit          got;
        logic [31:0] req_addr;
        logic [31:0] got_pc;
        reset_assert();
        reset_release();
        gnt_v = 1'b1;
        lat   = 3;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (mem_q.size() != 2) begin failures++; $display("FAIL branch_inflight: got %0d exp 2", mem_q.size()); end
        branch_v   = 1'b1;
        branch_tgt = 32'h0000_0103;
        step();
        branch_v = 1'b0;
        checks++;
        if (dut.state !== ST_FLUSH) begin failures++; $display("FAIL branch_flush_state: got %0d exp %0d", dut.state, ST_FLUSH); end
        seen_req = 1'b0;
        got      = 1'b0;
        req_addr = 32'hx;
        got_pc   = 32'hx;
        for (int i = 0; i < 30 && !got; i++) begin
            if (imem_req_o === 1'b1 && !seen_req) begin
                seen_req = 1'b1;
                req_addr = imem_addr_o;
            end
            if (inst_valid_o === 1'b1) begin
                got    = 1'b1;
                got_pc = pc_o;
            end else begin
                step();
            end
        end
        checks += 2;
        if (req_addr !== 32'h100) begin failures++; $display("FAIL branch_req_addr: got %h exp 00000100", req_addr); end
        if (!got || got_pc !== 32'h100) begin failures++; $display("FAIL branch_first_pc: got %h exp 00000100", got_pc); end
    endtask

    task automatic test_branch_stall_full();
        lat     = 1;
        gnt_v   = 1'b1;
        stall_v = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() < DEPTH; i++) step();
        checks++;
        if (inst_valid_o !== 1'b1 || exp_q.size() != DEPTH) begin
            failures++;
            $display("FAIL fill: got valid %b entries %0d exp 1/%0d", inst_valid_o, exp_q.size(), DEPTH);
        end
        branch_v   = 1'b1;
        branch_tgt = 32'h0000_0200;
        step();
        branch_v = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL branch_full_valid: got %b exp 0", inst_valid_o); end
        stall_v = 1'b0;
        for (int i = 0; i < 20 && inst_valid_o !== 1'b1; i++) step();
        checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h200) begin
            failures++;
            $display("FAIL branch_full_target: got valid %b pc %h exp 1/00000200", inst_valid_o, pc_o);
        end
    endtask

    task automatic test_wrap();
        int          n;
        logic [31:0] pcs [3];
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFFC;
        exp_pcs[1] = 32'h0000_0000;
        exp_pcs[2] = 32'h0000_0004;
        foreach (pcs[k]) pcs[k] = 32'hx;
        lat        = 1;
        gnt_v      = 1'b1;
        stall_v    = 1'b0;
        branch_v   = 1'b1;
        branch_tgt = 32'hFFFF_FFFE;
        step();
        branch_v = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            step();
            if (acc_flag) begin
                pcs[n] = acc_pc;
                n++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pcs[k] !== exp_pcs[k]) begin failures++; $display("FAIL wrap_pc%0d: got %h exp %h", k, pcs[k], exp_pcs[k]); end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        lat   = 2;
        gnt_v = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset_assert();
        checks += 4;
        if (imem_req_o !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b exp 0", imem_req_o); end
        if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b exp 0", inst_valid_o); end
        if (pc_o !== RST_PC) begin failures++; $display("FAIL midrst_pc: got %h exp %h", pc_o, RST_PC); end
        if (imem_addr_o !== RST_PC) begin failures++; $display("FAIL midrst_addr: got %h exp %h", imem_addr_o, RST_PC); end
        reset_release();
        gnt_v = 1'b1;
        lat   = 1;
        n     = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (acc_flag) n++;
        end
        checks++;
        if (n == 0) begin failures++; $display("FAIL midrst_restart: got 0 accepted exp at least 1"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            gnt_v      = ($urandom_range(0, 3) != 0);
            stall_v    = ($urandom_range(0, 3) == 0);
            rvalid_v   = ($urandom_range(0, 4) != 0);
            lat        = $urandom_range(1, 4);
            branch_v   = ($urandom_range(0, 19) == 0);
            branch_tgt = $urandom;
            step();
        end
        branch_v = 1'b0;
        gnt_v    = 1'b0;
        stall_v  = 1'b0;
        rvalid_v = 1'b1;
        for (int i = 0; i < 60 && (mem_q.size() != 0 || exp_q.size() != 0); i++) step();
        checks++;
        if (mem_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending %0d buffered exp 0/0", mem_q.size(), exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        epoch         = 0;
        lat           = 1;
        started       = 1'b0;
        acc_flag      = 1'b0;
        acc_pc        = 32'h0;
        exp_fetch_pc  = RST_PC;
        rst_n         = 1'b0;
        branch_i      = 1'b0;
        branch_pc_i   = 32'h0;
        stall_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        gnt_v         = 1'b0;
        stall_v       = 1'b0;
        rvalid_v      = 1'b1;
        branch_v      = 1'b0;
        branch_tgt    = 32'h0;

        test_reset();
        test_stream();
        test_stall();
        test_gnt_hold();
        test_branch();
        test_branch_stall_full();
        test_wrap();
        test_mid_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
